ex_mem_stage: RTL and testbench

EX/MEM pipeline boundary for the 16-bit WISC core, directly downstream of the ALU (adder, XOR, reduction, shifter, PADDSB). It registers the ALU result and memory/write-back controls into the MEM stage, holds the architectural N/Z/V flag register with per-opcode update rules, and supports stall, flush and halt. Branch logic in ID reads the flag outputs.

---
 rtl/wisc_pkg.sv | 66 ++++++
 rtl/ex_mem_stage_flag_unit.sv | 56 +++++
 rtl/ex_mem_stage.sv | 97 +++++++++
 tb/tb_ex_mem_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared types for the WISC EX/MEM boundary: opcodes, flag write masks, stage state, MEM payload.
package wisc_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned OP_W   = 4;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_ADD    = 4'h0;
   localparam opcode_t OP_SUB    = 4'h1;
   localparam opcode_t OP_XOR    = 4'h2;
   localparam opcode_t OP_RED    = 4'h3;
   localparam opcode_t OP_SLL    = 4'h4;
   localparam opcode_t OP_SRA    = 4'h5;
   localparam opcode_t OP_ROR    = 4'h6;
   localparam opcode_t OP_PADDSB = 4'h7;
   localparam opcode_t OP_LW     = 4'h8;
   localparam opcode_t OP_SW     = 4'h9;
   localparam opcode_t OP_LHB    = 4'hA;
   localparam opcode_t OP_LLB    = 4'hB;
   localparam opcode_t OP_B      = 4'hC;
   localparam opcode_t OP_BR     = 4'hD;
   localparam opcode_t OP_PCS    = 4'hE;
   localparam opcode_t OP_HLT    = 4'hF;

   // Per-flag write enables
   typedef struct packed {
      logic n;
      logic z;
      logic v;
   } flag_mask_t;

   localparam flag_mask_t FM_NONE = flag_mask_t'(3'b000);
   localparam flag_mask_t FM_Z    = flag_mask_t'(3'b010);
   localparam flag_mask_t FM_NZV  = flag_mask_t'(3'b111);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic                valid;
      logic                reg_wen;
      logic                mem_wen;
      logic                mem_ren;
      logic                halt;
      opcode_t             opcode;
      logic [REG_W-1:0]    rd;
      logic [DATA_W-1:0]   alu_out;
      logic [DATA_W-1:0]   store_data;
   } mem_pipe_t;

   function automatic flag_mask_t flag_mask(input opcode_t op);
      flag_mask_t m;
      m = FM_NONE;
      case (op)
         OP_ADD, OP_SUB:                 m = FM_NZV;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = FM_Z;
         default:                        m = FM_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ex_mem_stage_flag_unit.sv
// Architectural N/Z/V flag register with per-opcode write mask.
// With FLAG_BYPASS_EN defined the outputs expose next-state flags combinationally.
module flag_unit
   import wisc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_i,
   input  opcode_t           opcode_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic              ovfl_i,
   output logic              flag_n_o,
   output logic              flag_z_o,
   output logic              flag_v_o
);

   flag_mask_t mask_c;
   logic       n_q, z_q, v_q;
   logic       n_d, z_d, v_d;

   always_comb begin
      mask_c = flag_mask(opcode_i);
      n_d    = n_q;
      z_d    = z_q;
      v_d    = v_q;
      if (upd_i) begin
         if (mask_c.n) n_d = result_i[DATA_W-1];
         if (mask_c.z) z_d = (result_i == '0);
         if (mask_c.v) v_d = ovfl_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 1'b0;
         z_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         n_q <= n_d;
         z_q <= z_d;
         v_q <= v_d;
      end
   end

`ifdef FLAG_BYPASS_EN
   // ID sees the flags of the instruction currently in EX
   assign flag_n_o = n_d;
   assign flag_z_o = z_d;
   assign flag_v_o = v_d;
`else
   assign flag_n_o = n_q;
   assign flag_z_o = z_q;
   assign flag_v_o = v_q;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 16-bit WISC core with stall/flush, HLT retirement and flags.
// Optional FLAG_BYPASS_EN forwards next-state flags to ID in the same cycle.
module ex_mem_stage
   import wisc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [OP_W-1:0]   ex_opcode,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic              ex_ovfl,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_reg_wen,
   input  logic              ex_mem_wen,
   input  logic              ex_mem_ren,
   output logic              mem_valid,
   output logic              mem_reg_wen,
   output logic              mem_mem_wen,
   output logic              mem_mem_ren,
   output logic              mem_halt,
   output logic [OP_W-1:0]   mem_opcode,
   output logic [REG_W-1:0]  mem_rd,
   output logic [DATA_W-1:0] mem_alu_out,
   output logic [DATA_W-1:0] mem_store_data,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_v,
   output logic              halted
);

   state_t    state_q, state_d;
   mem_pipe_t mem_q, mem_d;
   logic      acc_c;

   assign acc_c = ex_valid & ~stall & ~flush & (state_q == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
      end
   end

   // Stall holds everything; any other non-accept cycle inserts a bubble with stale data
   always_comb begin
      state_d = state_q;
      mem_d   = mem_q;
      if (acc_c) begin
         mem_d.valid      = 1'b1;
         mem_d.reg_wen    = ex_reg_wen;
         mem_d.mem_wen    = ex_mem_wen;
         mem_d.mem_ren    = ex_mem_ren;
         mem_d.halt       = (ex_opcode == OP_HLT);
         mem_d.opcode     = ex_opcode;
         mem_d.rd         = ex_rd;
         mem_d.alu_out    = ex_alu_out;
         mem_d.store_data = ex_store_data;
         if (ex_opcode == OP_HLT) state_d = HALTED;
      end else if (!stall) begin
         mem_d.valid   = 1'b0;
         mem_d.reg_wen = 1'b0;
         mem_d.mem_wen = 1'b0;
         mem_d.mem_ren = 1'b0;
         mem_d.halt    = 1'b0;
      end
   end

   flag_unit u_flag_unit (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_i    (acc_c),
      .opcode_i (ex_opcode),
      .result_i (ex_alu_out),
      .ovfl_i   (ex_ovfl),
      .flag_n_o (flag_n),
      .flag_z_o (flag_z),
      .flag_v_o (flag_v)
   );

   assign mem_valid      = mem_q.valid;
   assign mem_reg_wen    = mem_q.reg_wen;
   assign mem_mem_wen    = mem_q.mem_wen;
   assign mem_mem_ren    = mem_q.mem_ren;
   assign mem_halt       = mem_q.halt;
   assign mem_opcode     = mem_q.opcode;
   assign mem_rd         = mem_q.rd;
   assign mem_alu_out    = mem_q.alu_out;
   assign mem_store_data = mem_q.store_data;
   assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver queues hand-computed post-edge outputs, monitor compares.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, ex_valid, ex_ovfl;
   logic [3:0]  ex_opcode, ex_rd;
   logic [15:0] ex_alu_out, ex_store_data;
   logic        ex_reg_wen, ex_mem_wen, ex_mem_ren;
   logic        mem_valid, mem_reg_wen, mem_mem_wen, mem_mem_ren, mem_halt;
   logic [3:0]  mem_opcode, mem_rd;
   logic [15:0] mem_alu_out, mem_store_data;
   logic        flag_n, flag_z, flag_v, halted;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        v, rw, mw, mr, h;
      logic [3:0]  op, rd;
      logic [15:0] alu, sd;
      logic        cd;
      logic        n, z, fv, hlt;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
      .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_wen(ex_reg_wen), .ex_mem_wen(ex_mem_wen), .ex_mem_ren(ex_mem_ren),
      .mem_valid(mem_valid), .mem_reg_wen(mem_reg_wen), .mem_mem_wen(mem_mem_wen),
      .mem_mem_ren(mem_mem_ren), .mem_halt(mem_halt), .mem_opcode(mem_opcode),
      .mem_rd(mem_rd), .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
      .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .halted(halted)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one queued expectation per clock edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("mem_valid",   16'(mem_valid),   16'(e.v));
         chk("mem_reg_wen", 16'(mem_reg_wen), 16'(e.rw));
         chk("mem_mem_wen", 16'(mem_mem_wen), 16'(e.mw));
         chk("mem_mem_ren", 16'(mem_mem_ren), 16'(e.mr));
         chk("mem_halt",    16'(mem_halt),    16'(e.h));
         chk("halted",      16'(halted),      16'(e.hlt));
         if (e.cd) begin
            chk("mem_opcode",     16'(mem_opcode), 16'(e.op));
            chk("mem_rd",         16'(mem_rd),     16'(e.rd));
            chk("mem_alu_out",    mem_alu_out,     e.alu);
            chk("mem_store_data", mem_store_data,  e.sd);
         end
`ifndef FLAG_BYPASS_EN
         chk("flag_n", 16'(flag_n), 16'(e.n));
         chk("flag_z", 16'(flag_z), 16'(e.z));
         chk("flag_v", 16'(flag_v), 16'(e.fv));
`endif
      end
   end

   task automatic go(
      input logic vld, input logic [3:0] op, input logic [15:0] alu, input logic ovf,
      input logic [15:0] sd, input logic [3:0] rd, input logic rw, input logic mw,
      input logic mr, input logic st, input logic fl,
      input logic ev, input logic erw, input logic emw, input logic emr, input logic eh,
      input logic [3:0] eop, input logic [3:0] erd, input logic [15:0] ealu,
      input logic [15:0] esd, input logic ecd,
      input logic en, input logic ez, input logic efv, input logic ehlt);
      exp_t e;
      @(negedge clk);
      ex_valid = vld; ex_opcode = op; ex_alu_out = alu; ex_ovfl = ovf;
      ex_store_data = sd; ex_rd = rd; ex_reg_wen = rw; ex_mem_wen = mw;
      ex_mem_ren = mr; stall = st; flush = fl;
      e = '{v:ev, rw:erw, mw:emw, mr:emr, h:eh, op:eop, rd:erd, alu:ealu, sd:esd,
            cd:ecd, n:en, z:ez, fv:efv, hlt:ehlt};
      q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      ex_valid = 1'b0; ex_opcode = 4'h0; ex_alu_out = 16'h0; ex_ovfl = 1'b0;
      ex_store_data = 16'h0; ex_rd = 4'h0; ex_reg_wen = 1'b0; ex_mem_wen = 1'b0;
      ex_mem_ren = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"},  16'(mem_valid),   16'h0);
      chk({tag, "_wens"},   16'({mem_reg_wen, mem_mem_wen, mem_mem_ren}), 16'h0);
      chk({tag, "_halt"},   16'(mem_halt),    16'h0);
      chk({tag, "_alu"},    mem_alu_out,      16'h0000);
      chk({tag, "_sd"},     mem_store_data,   16'h0000);
      chk({tag, "_rd"},     16'(mem_rd),      16'h0);
      chk({tag, "_op"},     16'(mem_opcode),  16'h0);
      chk({tag, "_flags"},  16'({flag_n, flag_z, flag_v}), 16'h0);
      chk({tag, "_halted"}, 16'(halted),      16'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_opcode = 4'h0; ex_alu_out = 16'h0; ex_ovfl = 1'b0;
      ex_store_data = 16'h0; ex_rd = 4'h0; ex_reg_wen = 1'b0; ex_mem_wen = 1'b0;
      ex_mem_ren = 1'b0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      //  vld op    alu      ov sd       rd   rw mw mr st fl | v rw mw mr h op   rd   alu      sd       cd  n  z  v  hlt
      go(1, 4'h0, 16'h8000, 1, 16'h1111, 4'h3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h0, 4'h3, 16'h8000, 16'h1111, 1, 1, 0, 1, 0);
      go(1, 4'h2, 16'h0000, 1, 16'h0000, 4'h2, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h2, 4'h2, 16'h0000, 16'h0000, 1, 1, 1, 1, 0);
      go(1, 4'h1, 16'h0000, 0, 16'h2222, 4'h4, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h1, 4'h4, 16'h0000, 16'h2222, 1, 0, 1, 0, 0);
      go(1, 4'h4, 16'h0010, 1, 16'h0000, 4'h5, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h4, 4'h5, 16'h0010, 16'h0000, 1, 0, 0, 0, 0);
      go(1, 4'h0, 16'h8001, 0, 16'h0000, 4'h6, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h0, 4'h6, 16'h8001, 16'h0000, 1, 1, 0, 0, 0);
      go(1, 4'h8, 16'h0000, 0, 16'h0000, 4'h7, 1, 0, 1, 0, 0,  1, 1, 0, 1, 0, 4'h8, 4'h7, 16'h0000, 16'h0000, 1, 1, 0, 0, 0);
      go(1, 4'h9, 16'h0040, 0, 16'hBEEF, 4'h0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 4'h9, 4'h0, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0);
      // stall and flush together: everything holds
      go(1, 4'h2, 16'h0000, 0, 16'h0000, 4'h9, 1, 0, 0, 1, 1,  1, 0, 1, 0, 0, 4'h9, 4'h0, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0);
      go(1, 4'h2, 16'h0000, 0, 16'h0000, 4'h9, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
      go(1, 4'h0, 16'h0000, 0, 16'h0000, 4'h1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
      go(0, 4'h0, 16'h0000, 0, 16'h0000, 4'h1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
      go(1, 4'h7, 16'h0000, 0, 16'h0000, 4'h1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h7, 4'h1, 16'h0000, 16'h0000, 1, 1, 0, 0, 0);
      go(1, 4'h0, 16'h0005, 0, 16'h0000, 4'h1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h0, 4'h1, 16'h0005, 16'h0000, 1, 0, 0, 0, 0);
      // HLT retires; later instructions are bubbles with frozen flags
      go(1, 4'hF, 16'h0000, 0, 16'h0000, 4'h0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 4'hF, 4'h0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);
      go(1, 4'h0, 16'h0000, 0, 16'h0000, 4'h2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
      go(1, 4'h6, 16'h0000, 1, 16'h0000, 4'h2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
      drain();

      // Asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      go(1, 4'h0, 16'h8000, 1, 16'h0000, 4'h3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 4'h0, 4'h3, 16'h8000, 16'h0000, 1, 1, 0, 1, 0);
      drain();
      idle();

`ifdef FLAG_BYPASS_EN
      @(negedge clk);
      ex_valid = 1'b1; ex_opcode = 4'h6; ex_alu_out = 16'h0000;
      #1 chk("bypass_flag_z", 16'(flag_z), 16'h1);
      idle();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
